// File: rtl/yarvi_mem_arb_if.sv
//------------------------------------------------------------------------------
// Module  : yarvi_mem_arb_if
// Brief   : Two requester ports, their read-response returns and the memory port.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface yarvi_mem_arb_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_addr;
    logic        req0_we;
    logic [31:0] req0_wdata;
    logic [3:0]  req0_wmask;

    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_addr;
    logic        req1_we;
    logic [31:0] req1_wdata;
    logic [3:0]  req1_wmask;

    logic        rsp0_valid;
    logic [31:0] rsp0_data;
    logic        rsp1_valid;
    logic [31:0] rsp1_data;

    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_addr, req0_we, req0_wdata, req0_wmask,
        input  req1_valid, req1_addr, req1_we, req1_wdata, req1_wmask,
        input  mem_ready, mem_rdata,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        output mem_valid, mem_addr, mem_we, mem_wdata, mem_wmask
    );

    // Requesters and memory side.
    modport master (
        output req0_valid, req0_addr, req0_we, req0_wdata, req0_wmask,
        output req1_valid, req1_addr, req1_we, req1_wdata, req1_wmask,
        output mem_ready, mem_rdata,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        input  mem_valid, mem_addr, mem_we, mem_wdata, mem_wmask
    );
endinterface

`default_nettype wire

// File: rtl/yarvi_mem_arb.sv
//------------------------------------------------------------------------------
// Module  : yarvi_mem_arb
// Brief   : Round-robin data-memory arbiter with starvation guard and read-id pipe.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module yarvi_mem_arb #(
    parameter int LAT      = 1,
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic           clock,
    input  logic           reset,
    yarvi_mem_arb_if.slave bus
);

    localparam logic [WAIT_W-1:0] C_WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] C_WAIT_SAT = '1;

    logic              w_force;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_acc0;
    logic              w_acc1;
    logic              w_accept;
    logic              w_rd_issue;
    logic [LAT-1:0]    w_pv_next;
    logic [LAT-1:0]    w_pid_next;

    logic              r_last_grant;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [LAT-1:0]    r_pv;
    logic [LAT-1:0]    r_pid;

    // Requester 1 wins a tie when requester 0 won last, or when it has waited too long.
    always_comb begin
        w_force  = bus.req1_valid && (r_wait_cnt >= C_WAIT_MAX);
        w_grant1 = bus.req1_valid && (!bus.req0_valid || w_force || !r_last_grant);
        w_grant0 = bus.req0_valid && !w_grant1;
    end

    assign bus.req0_ready = w_grant0 & bus.mem_ready & ~reset;
    assign bus.req1_ready = w_grant1 & bus.mem_ready & ~reset;
    assign w_acc0         = bus.req0_valid & bus.req0_ready;
    assign w_acc1         = bus.req1_valid & bus.req1_ready;
    assign w_accept       = w_acc0 | w_acc1;

    assign bus.mem_valid  = (bus.req0_valid | bus.req1_valid) & ~reset;
    assign bus.mem_addr   = w_grant1 ? bus.req1_addr  : bus.req0_addr;
    assign bus.mem_we     = w_grant1 ? bus.req1_we    : bus.req0_we;
    assign bus.mem_wdata  = w_grant1 ? bus.req1_wdata : bus.req0_wdata;
    assign bus.mem_wmask  = ~bus.mem_we ? 4'h0 :
                            (w_grant1 ? bus.req1_wmask : bus.req0_wmask);

    assign w_rd_issue     = w_accept & ~bus.mem_we;

    generate
        if (LAT == 1) begin : g_lat_one
            assign w_pv_next  = w_rd_issue;
            assign w_pid_next = w_grant1;
        end else begin : g_lat_multi
            assign w_pv_next  = {r_pv[LAT-2:0],  w_rd_issue};
            assign w_pid_next = {r_pid[LAT-2:0], w_grant1};
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_wait_cnt   <= '0;
            r_pv         <= '0;
            r_pid        <= '0;
        end else begin
            if (w_accept) begin
                r_last_grant <= w_grant1;
            end
            if (!bus.req1_valid || w_acc1) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != C_WAIT_SAT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            // Fixed latency: the id pipe advances even while memory is stalled.
            r_pv  <= w_pv_next;
            r_pid <= w_pid_next;
        end
    end

    assign bus.rsp0_valid = r_pv[LAT-1] & ~r_pid[LAT-1] & ~reset;
    assign bus.rsp1_valid = r_pv[LAT-1] &  r_pid[LAT-1] & ~reset;
    assign bus.rsp0_data  = bus.mem_rdata;
    assign bus.rsp1_data  = bus.mem_rdata;

    // Requesters must hold their fields while waiting; flag any change.
    logic [68:0] w_f0;
    logic [68:0] w_f1;
    logic [68:0] r_f0;
    logic [68:0] r_f1;
    logic        r_hold0;
    logic        r_hold1;

    assign w_f0 = {bus.req0_addr, bus.req0_we, bus.req0_wdata, bus.req0_wmask};
    assign w_f1 = {bus.req1_addr, bus.req1_we, bus.req1_wdata, bus.req1_wmask};

    always_ff @(posedge clock) begin
        r_f0    <= w_f0;
        r_f1    <= w_f1;
        r_hold0 <= bus.req0_valid & ~bus.req0_ready & ~reset;
        r_hold1 <= bus.req1_valid & ~bus.req1_ready & ~reset;
        if (!reset) begin
            assert (!(r_hold0 && bus.req0_valid && (w_f0 != r_f0)))
                else $error("yarvi_mem_arb: req0 fields changed while stalled");
            assert (!(r_hold1 && bus.req1_valid && (w_f1 != r_f1)))
                else $error("yarvi_mem_arb: req1 fields changed while stalled");
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_yarvi_mem_arb.sv
//------------------------------------------------------------------------------
// Module  : tb_yarvi_mem_arb
// Brief   : Directed vector table plus hand sequences for yarvi_mem_arb.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_yarvi_mem_arb;

    localparam logic [31:0] C_WDATA0 = 32'h1111_0000;
    localparam logic [31:0] C_WDATA1 = 32'h2222_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        v0, we0, v1, we1, mrdy;
    logic [3:0]  m0;
    logic [31:0] a0, a1, rdata;

    always #5 clock = ~clock;

    yarvi_mem_arb_if if_a ();
    yarvi_mem_arb_if if_b ();

    assign if_a.req0_valid = v0;
    assign if_a.req0_addr  = a0;
    assign if_a.req0_we    = we0;
    assign if_a.req0_wdata = C_WDATA0;
    assign if_a.req0_wmask = m0;
    assign if_a.req1_valid = v1;
    assign if_a.req1_addr  = a1;
    assign if_a.req1_we    = we1;
    assign if_a.req1_wdata = C_WDATA1;
    assign if_a.req1_wmask = 4'hF;
    assign if_a.mem_ready  = mrdy;
    assign if_a.mem_rdata  = rdata;

    assign if_b.req0_valid = v0;
    assign if_b.req0_addr  = a0;
    assign if_b.req0_we    = we0;
    assign if_b.req0_wdata = C_WDATA0;
    assign if_b.req0_wmask = m0;
    assign if_b.req1_valid = v1;
    assign if_b.req1_addr  = a1;
    assign if_b.req1_we    = we1;
    assign if_b.req1_wdata = C_WDATA1;
    assign if_b.req1_wmask = 4'hF;
    assign if_b.mem_ready  = mrdy;
    assign if_b.mem_rdata  = rdata;

    yarvi_mem_arb #(.LAT(1), .MAX_WAIT(15), .WAIT_W(4)) u_dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (if_a.slave)
    );

    yarvi_mem_arb #(.LAT(2), .MAX_WAIT(3), .WAIT_W(2)) u_dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (if_b.slave)
    );

    // ci = {reset, v0, we0, v1, we1, mem_ready}
    // ex = {req0_ready, req1_ready, mem_valid, mem_we, rsp0_valid, rsp1_valid}
    typedef struct {
        logic [5:0]  ci;
        logic [3:0]  m0;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] rd;
        logic [5:0]  ex;
        logic [31:0] maddr;
        logic [3:0]  mmask;
    } vec_t;

    vec_t tbl [22];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] c, input logic [3:0] m,
                         input logic [31:0] x0, input logic [31:0] x1, input logic [31:0] rd);
        {reset, v0, we0, v1, we1, mrdy} = c;
        m0    = m;
        a0    = x0;
        a1    = x1;
        rdata = rd;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset, then single req0 read with a non-zero mask that must be suppressed.
        tbl[0]  = '{6'b110101, 4'h0, 32'h0,         32'h0,   32'h0,         6'b000000, 32'h0,         4'h0};
        tbl[1]  = '{6'b110101, 4'h0, 32'h0,         32'h0,   32'h0,         6'b000000, 32'h0,         4'h0};
        tbl[2]  = '{6'b010001, 4'hF, 32'h8000_0010, 32'h0,   32'h0,         6'b101000, 32'h8000_0010, 4'h0};
        tbl[3]  = '{6'b000001, 4'h0, 32'h0,         32'h0,   32'hDEAD_BEEF, 6'b000010, 32'h0,         4'h0};
        // Continuous reads from both requesters after reset.
        tbl[4]  = '{6'b100001, 4'h0, 32'h0,         32'h0,   32'h0,         6'b000000, 32'h0,         4'h0};
        tbl[5]  = '{6'b010101, 4'h0, 32'h100,       32'h200, 32'h0,         6'b101000, 32'h100,       4'h0};
        tbl[6]  = '{6'b010101, 4'h0, 32'h104,       32'h200, 32'hA0,        6'b011010, 32'h200,       4'h0};
        tbl[7]  = '{6'b010101, 4'h0, 32'h104,       32'h204, 32'hA1,        6'b101001, 32'h104,       4'h0};
        tbl[8]  = '{6'b010101, 4'h0, 32'h108,       32'h204, 32'hA2,        6'b011010, 32'h204,       4'h0};
        tbl[9]  = '{6'b000001, 4'h0, 32'h0,         32'h0,   32'hA3,        6'b000001, 32'h0,         4'h0};
        // Five stalled cycles with both valid; pending winner req0 store.
        tbl[10] = '{6'b011100, 4'h3, 32'h300,       32'h400, 32'h0,         6'b001100, 32'h300,       4'h3};
        tbl[11] = '{6'b011100, 4'h3, 32'h300,       32'h400, 32'h0,         6'b001100, 32'h300,       4'h3};
        tbl[12] = '{6'b011100, 4'h3, 32'h300,       32'h400, 32'h0,         6'b001100, 32'h300,       4'h3};
        tbl[13] = '{6'b011100, 4'h3, 32'h300,       32'h400, 32'h0,         6'b001100, 32'h300,       4'h3};
        tbl[14] = '{6'b011100, 4'h3, 32'h300,       32'h400, 32'h0,         6'b001100, 32'h300,       4'h3};
        tbl[15] = '{6'b011101, 4'h3, 32'h300,       32'h400, 32'h0,         6'b101100, 32'h300,       4'h3};
        tbl[16] = '{6'b000101, 4'h0, 32'h0,         32'h400, 32'h0,         6'b011000, 32'h400,       4'h0};
        tbl[17] = '{6'b000001, 4'h0, 32'h0,         32'h0,   32'hB1,        6'b000001, 32'h0,         4'h0};
        // Store vs read on the first cycle after reset.
        tbl[18] = '{6'b100001, 4'h0, 32'h0,         32'h0,   32'h0,         6'b000000, 32'h0,         4'h0};
        tbl[19] = '{6'b011101, 4'hC, 32'h8000_0002, 32'h500, 32'h0,         6'b101100, 32'h8000_0002, 4'hC};
        tbl[20] = '{6'b000101, 4'h0, 32'h0,         32'h500, 32'h0,         6'b011000, 32'h500,       4'h0};
        tbl[21] = '{6'b000001, 4'h0, 32'h0,         32'h0,   32'hC3,        6'b000001, 32'h0,         4'h0};

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].ci, tbl[i].m0, tbl[i].a0, tbl[i].a1, tbl[i].rd);
            @(negedge clock);
            chk($sformatf("r%0d req0_ready", i), 32'(if_a.req0_ready), 32'(tbl[i].ex[5]));
            chk($sformatf("r%0d req1_ready", i), 32'(if_a.req1_ready), 32'(tbl[i].ex[4]));
            chk($sformatf("r%0d mem_valid", i),  32'(if_a.mem_valid),  32'(tbl[i].ex[3]));
            chk($sformatf("r%0d rsp0_valid", i), 32'(if_a.rsp0_valid), 32'(tbl[i].ex[1]));
            chk($sformatf("r%0d rsp1_valid", i), 32'(if_a.rsp1_valid), 32'(tbl[i].ex[0]));
            if (tbl[i].ex[3]) begin
                chk($sformatf("r%0d mem_addr", i),  if_a.mem_addr,         tbl[i].maddr);
                chk($sformatf("r%0d mem_we", i),    32'(if_a.mem_we),      32'(tbl[i].ex[2]));
                chk($sformatf("r%0d mem_wmask", i), 32'(if_a.mem_wmask),   32'(tbl[i].mmask));
                if (tbl[i].ex[2]) begin
                    chk($sformatf("r%0d mem_wdata", i), if_a.mem_wdata, C_WDATA0);
                end
            end
            if (tbl[i].ex[1]) chk($sformatf("r%0d rsp0_data", i), if_a.rsp0_data, tbl[i].rd);
            if (tbl[i].ex[0]) chk($sformatf("r%0d rsp1_data", i), if_a.rsp1_data, tbl[i].rd);
            step();
        end

        // Starvation: req1 refused three cycles, then forced past a req0 tie win.
        drive(6'b100000, 4'h0, 32'h0, 32'h0, 32'h0);
        step();
        drive(6'b010100, 4'h0, 32'h700, 32'h600, 32'h0);
        @(negedge clock);
        chk("s1 b mem_addr", if_b.mem_addr, 32'h700);
        step();
        drive(6'b000100, 4'h0, 32'h0, 32'h600, 32'h0);
        @(negedge clock);
        chk("s2 b req1_ready", 32'(if_b.req1_ready), 32'd0);
        step();
        drive(6'b010100, 4'h0, 32'h700, 32'h600, 32'h0);
        @(negedge clock);
        chk("s3 b mem_addr", if_b.mem_addr, 32'h700);
        step();
        drive(6'b010101, 4'h0, 32'h700, 32'h600, 32'h0);
        @(negedge clock);
        chk("s4 b req1_ready", 32'(if_b.req1_ready), 32'd1);
        chk("s4 b req0_ready", 32'(if_b.req0_ready), 32'd0);
        chk("s4 b mem_addr",   if_b.mem_addr,        32'h600);
        chk("s4 a req0_ready", 32'(if_a.req0_ready), 32'd1);
        step();
        drive(6'b000001, 4'h0, 32'h0, 32'h0, 32'h55);
        @(negedge clock);
        chk("s5 b wait_cnt",   32'(u_dut_b.r_wait_cnt), 32'd0);
        chk("s5 b rsp1_valid", 32'(if_b.rsp1_valid),    32'd0);
        chk("s5 a rsp0_valid", 32'(if_a.rsp0_valid),    32'd1);
        step();
        drive(6'b000001, 4'h0, 32'h0, 32'h0, 32'h66);
        @(negedge clock);
        chk("s6 b rsp1_valid", 32'(if_b.rsp1_valid), 32'd1);
        chk("s6 b rsp1_data",  if_b.rsp1_data,       32'h66);
        step();

        // Reset with two reads in flight on the LAT=2 instance.
        drive(6'b100000, 4'h0, 32'h0, 32'h0, 32'h0);
        step();
        drive(6'b010001, 4'h0, 32'h800, 32'h0, 32'h0);
        @(negedge clock);
        chk("d1 b req0_ready", 32'(if_b.req0_ready), 32'd1);
        step();
        drive(6'b000101, 4'h0, 32'h0, 32'h900, 32'h0);
        @(negedge clock);
        chk("d2 b req1_ready", 32'(if_b.req1_ready), 32'd1);
        step();
        drive(6'b110101, 4'h0, 32'hA00, 32'hB00, 32'h0);
        @(negedge clock);
        chk("d3 b rsp0_valid", 32'(if_b.rsp0_valid), 32'd0);
        chk("d3 b mem_valid",  32'(if_b.mem_valid),  32'd0);
        chk("d3 b req0_ready", 32'(if_b.req0_ready), 32'd0);
        step();
        drive(6'b010101, 4'h0, 32'hA00, 32'hB00, 32'h0);
        @(negedge clock);
        chk("d4 b rsp1_valid", 32'(if_b.rsp1_valid), 32'd0);
        chk("d4 b req0_ready", 32'(if_b.req0_ready), 32'd1);
        chk("d4 b mem_addr",   if_b.mem_addr,        32'hA00);
        step();
        drive(6'b000001, 4'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clock);
        chk("d5 b rsp0_valid", 32'(if_b.rsp0_valid), 32'd0);
        chk("d5 b rsp1_valid", 32'(if_b.rsp1_valid), 32'd0);
        step();
        drive(6'b000001, 4'h0, 32'h0, 32'h0, 32'h77);
        @(negedge clock);
        chk("d6 b rsp0_valid", 32'(if_b.rsp0_valid), 32'd1);
        chk("d6 b rsp0_data",  if_b.rsp0_data,       32'h77);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/yarvi_mem_arb.md
Name: yarvi_mem_arb

Overview:
- Two-requester arbiter for the single data-memory port.
- Requester 0 is the core load/store unit. Requester 1 is the debug/loader master.
- Selects one request per cycle with round-robin plus a starvation guard.
- Tracks outstanding reads in a fixed-latency tag pipeline and routes each read result back to the requester that issued it.

Parameters:
- LAT, 1: fixed read latency of the memory, in cycles from accept to mem_rdata valid (1..4).
- MAX_WAIT, 15: cycles requester 1 may be refused while valid before it is forced to win.
- WAIT_W, 4: width of the starvation counter; must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous active-high reset
- req0_valid  in  1  requester 0 request
- req0_ready  out  1  requester 0 accepted this cycle
- req0_addr  in  32  byte address
- req0_we  in  1  1=store, 0=load
- req0_wdata  in  32  pre-aligned store data
- req0_wmask  in  4  byte-lane mask
- req1_valid, req1_ready, req1_addr, req1_we, req1_wdata, req1_wmask: as requester 0, for requester 1
- rsp0_valid  out  1  read data for requester 0
- rsp0_data  out  32  read data
- rsp1_valid  out  1  read data for requester 1
- rsp1_data  out  32  read data
- mem_valid  out  1  request to memory
- mem_ready  in  1  memory can accept this cycle
- mem_addr  out  32  selected address
- mem_we  out  1  selected write enable
- mem_wdata  out  32  selected write data
- mem_wmask  out  4  selected mask; forced to 0 when mem_we=0
- mem_rdata  in  32  read data, LAT cycles after accept

Behaviour:
- Interface: reset is synchronous, active-high; clock is `clock`.
- Grant is combinational from the current request valids, last_grant and the wait counter. There are no bubbles.
  - Only one requester valid: it gets the grant.
  - Both valid: the requester that is not last_grant wins.
  - Override: if wait_cnt >= MAX_WAIT and req1_valid, requester 1 wins.
- Acceptance:
  - reqN_ready = grantN & mem_ready & !reset.
  - A request is accepted when reqN_valid & reqN_ready.
  - mem_valid = (req0_valid | req1_valid) & !reset.
  - mem_* carries the granted requester's fields whether or not mem_ready is high.
  - Requesters must hold their fields stable while valid and not ready; the arbiter does not re-register them.
- last_grant:
  - Updated only on accept, to the accepted requester index.
  - Holds otherwise. This includes mem_ready=0, so the decision does not flip while stalled.
- wait_cnt:
  - Increments, saturating at 2^WAIT_W-1, on each cycle where req1_valid & !(req1 accepted).
  - Clears to 0 on requester 1 accept, or when req1_valid=0.
- Read tracking:
  - A shift pipeline LAT entries deep, each entry {v, id}.
  - On accept of a read (mem_we=0), stage 0 gets {1, granted id}; otherwise stage 0 gets {0, x}.
  - The pipeline shifts every cycle regardless of mem_ready, because latency is fixed.
- Response:
  - When the last stage has v=1, rspN_valid = (id==N) for exactly that cycle.
  - Both rspN_data are driven with mem_rdata combinationally.
  - Writes produce no response.
- Throughput: back-to-back reads from alternating or same requesters, one per cycle. Responses return in issue order.
- Reset, effective same edge:
  - All pipeline v=0, last_grant=1 (so requester 0 wins the first contended cycle), wait_cnt=0.
  - While reset is high: rsp0_valid=rsp1_valid=0, req0_ready=req1_ready=0, mem_valid=0.
  - Reset mid-operation drops in-flight reads; no response is delivered for them.
- Simultaneous events:
  - A response and a new accept in the same cycle are independent.
  - The override can fire in the same cycle as a round-robin tie; the override wins.
- Simulation check: $display an error if any reqN fields change while valid & !ready.

Test Plan:
1. Reset, then req0 read 0x80000010 alone with mem_ready=1 and LAT=1 → req0_ready=1 in cycle 0; rsp0_valid=1 with mem_rdata in cycle 1; rsp1_valid=0.
2. Both requesters issue continuous reads from reset → grants alternate 0,1,0,1; responses return with ids 0,1,0,1 exactly LAT cycles after each accept.
3. req0 store mask 0xC at 0x80000002 and req1 read in the same cycle, both fresh after reset → store granted first with mem_wmask=0xC and no rsp0; read granted next cycle; rsp1_valid LAT cycles later.
4. mem_ready=0 for 5 cycles with both valid → no readys, last_grant and mem_* stable; on mem_ready=1 the pending winner is accepted first.
5. Starvation:
   - Setup: MAX_WAIT=3; requester 1 issues a continuous read; requester 0 issues a request that is withdrawn and reissued while mem_ready toggles, so requester 1 keeps losing.
   - Required response: requester 1 is granted no later than the 4th refused cycle; wait_cnt=0 after.
6. Reset asserted with LAT=2 and two reads in flight → no rsp*_valid in the following cycles; first post-reset contended grant goes to requester 0.
